// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the instruction/data Wishbone memory arbiter:
//   - FSM state encoding (IDLE, BUS, RESP)
//   - requester/owner identifiers (OWN_IF = 0, OWN_D = 1)
//   - default bus timeout and Wishbone width constants
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // The owner ID doubles as the bit index into the {d_req, if_req} vector.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 16;   // covers the full 1..65535 timeout range
  localparam int WB_AW       = 32;
  localparam int WB_DW       = 32;

endpackage : wb_arb_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic, purely combinational.
//   req      in   [1:0]  request vector, bit index = owner ID
//   last_gnt in   owner  owner of the previous grant
//   gnt      out  [1:0]  one-hot grant (all zero when nobody requests)
//   gnt_id   out  owner  encoded grant; only meaningful when |gnt
// -----------------------------------------------------------------------------
module rr_arb2
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_gnt,
  output logic [1:0] gnt,
  output owner_e     gnt_id
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    gnt    = 2'b00;
    gnt_id = OWN_IF;
    unique case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = OWN_IF;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = OWN_D;
      end
      2'b11: begin
        // On a tie the requester that did not win last time goes first.
        gnt_id = (last_gnt == OWN_IF) ? OWN_D : OWN_IF;
        gnt    = (last_gnt == OWN_IF) ? 2'b10 : 2'b01;
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = OWN_IF;
      end
    endcase
  end

endmodule : rr_arb2

// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
// Shares one classic Wishbone master port between the instruction-fetch unit
// (IF, read-only) and the load/store unit (D, read/write). One Wishbone cycle
// is run per grant; the owner gets a one-cycle done/err pulse afterwards.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   if_req/if_addr             IF request (held until if_done/if_err)
//   if_rdata/if_done/if_err    IF read data and termination pulses
//   d_req/d_we/d_addr/d_wdata/d_sel   D request and write payload
//   d_rdata/d_done/d_err       D read data and termination pulses
//   wb_cyc_o/wb_stb_o/wb_we_o/wb_adr_o/wb_dat_o/wb_sel_o   Wishbone master
//   wb_dat_i/wb_ack_i/wb_err_i                             Wishbone slave side
//
// Flow: IDLE (arbitrate, latch request) -> BUS (cyc/stb until ack, err or
// timeout) -> RESP (done/err pulse) -> IDLE. All outputs are registered.
// -----------------------------------------------------------------------------
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  // instruction fetch
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_done,
  output logic            if_err,
  // load/store
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_sel,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            d_err,
  // Wishbone master
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // FSM and latched request
  state_e            state_q,    state_d;
  owner_e            owner_q,    owner_d;
  owner_e            last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [AW-1:0]     adr_q,      adr_d;
  logic              we_q,       we_d;
  logic [DW-1:0]     dat_q,      dat_d;
  logic [DW/8-1:0]   sel_q,      sel_d;

  // registered outputs
  logic              cyc_q,      cyc_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     d_rdata_q,  d_rdata_d;
  logic              if_done_q,  if_done_d;
  logic              if_err_q,   if_err_d;
  logic              d_done_q,   d_done_d;
  logic              d_err_q,    d_err_d;

  // arbitration
  logic [1:0]        gnt;
  owner_e            gnt_id;
  logic              grant;
  logic              bus_end;

  rr_arb2 u_rr_arb2 (
    .req      ({d_req, if_req}),
    .last_gnt (last_gnt_q),
    .gnt      (gnt),
    .gnt_id   (gnt_id)
  );

  assign grant = (state_q == ST_IDLE) && (gnt != 2'b00);

  // Any termination source ends the bus cycle; ack/err priority is resolved
  // in the output logic.
  assign bus_end = (state_q == ST_BUS) &&
                   (wb_ack_i || wb_err_i || (cnt_q == CNT_LAST));

  // ---------------------------------------------------------------------------
  // State register (also holds the latched request and the output registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      last_gnt_q <= OWN_D;     // IF wins the first tie after reset
      cnt_q      <= '0;
      adr_q      <= '0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      sel_q      <= '0;
      cyc_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      d_done_q   <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      cyc_q      <= cyc_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      d_done_q   <= d_done_d;
      d_err_q    <= d_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: transitions, request latching, timeout counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    we_d       = we_q;
    dat_d      = dat_q;
    sel_d      = sel_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d    = ST_BUS;
          owner_d    = gnt_id;
          last_gnt_d = gnt_id;
          cnt_d      = '0;
          if (gnt_id == OWN_D) begin
            adr_d = d_addr;
            we_d  = d_we;
            dat_d = d_wdata;
            sel_d = d_sel;
          end else begin
            // Fetches are always full-word reads.
            adr_d = if_addr;
            we_d  = 1'b0;
            dat_d = '0;
            sel_d = '1;
          end
        end
      end
      ST_BUS: begin
        if (bus_end) state_d = ST_RESP;
        else         cnt_d   = cnt_q + 1'b1;
      end
      ST_RESP: begin
        // Requests are ignored here; the requester drops req at the end of
        // this cycle, so a still-high req in IDLE is a new request.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cyc_d      = 1'b0;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    d_done_d   = 1'b0;
    d_err_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    if (grant) begin
      cyc_d = 1'b1;
    end else if (state_q == ST_BUS) begin
      cyc_d = !bus_end;
      if (bus_end) begin
        if (wb_ack_i) begin
          // Ack wins over a simultaneous err. Writes leave rdata untouched.
          if (owner_q == OWN_D) begin
            d_done_d = 1'b1;
            if (!we_q) d_rdata_d = wb_dat_i;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = wb_dat_i;
          end
        end else begin
          // Bus error or timeout.
          if (owner_q == OWN_D) d_err_d  = 1'b1;
          else                  if_err_d = 1'b1;
        end
      end
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_done  = if_done_q;
  assign if_err   = if_err_q;
  assign d_done   = d_done_q;
  assign d_err    = d_err_q;

endmodule : wb_mem_arbiter

// File: tb/tb_wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_arbiter
// Directed stimulus for wb_mem_arbiter. Each access pushes a slave behaviour
// (wait states, ack/err/none, read data) and an expected response into queues.
// A negedge monitor plays the Wishbone slave, records what the arbiter drove
// on the bus, and compares every done/err pulse against the expected queue.
// -----------------------------------------------------------------------------
module tb_wb_mem_arbiter;

  localparam int TO = 4;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  typedef struct {
    int          mode;
    int          wait_n;
    logic [31:0] data;
  } slv_t;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] other_rdata;
    int          len;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          len;
    bit          stable;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done, if_err;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata;
  logic        d_done, d_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_sel    (d_sel),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .d_err    (d_err),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  int resp_cnt = 0;

  slv_t slv_q[$];
  exp_t exp_q[$];
  obs_t obs_q[$];
  logic [31:0] mdl_rdata [2];   // index 0 = IF, 1 = D

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slave model + response monitor (single block so bus records are pushed
  // before the response in the same cycle is compared)
  // ---------------------------------------------------------------------------
  bit   in_acc    = 1'b0;
  bit   prev_resp = 1'b0;
  int   acc_n;
  slv_t cur_slv;
  obs_t cur_obs;

  always @(negedge clk) begin
    bit   resp;
    exp_t e;
    obs_t o;

    if (wb_cyc_o) begin
      if (!in_acc) begin
        in_acc  = 1'b1;
        acc_n   = 0;
        cur_obs = '{addr: wb_adr_o, we: wb_we_o, sel: wb_sel_o,
                    wdata: wb_dat_o, len: 0, stable: 1'b1};
        check("slave_cfg_avail", 64'(slv_q.size() != 0), 64'd1);
        if (slv_q.size() != 0) cur_slv = slv_q.pop_front();
        else                   cur_slv = '{mode: M_NONE, wait_n: 0, data: '0};
      end else if (wb_adr_o !== cur_obs.addr || wb_we_o !== cur_obs.we ||
                   wb_sel_o !== cur_obs.sel || wb_dat_o !== cur_obs.wdata) begin
        cur_obs.stable = 1'b0;
      end
      if (wb_stb_o !== 1'b1) cur_obs.stable = 1'b0;
      cur_obs.len++;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (acc_n == cur_slv.wait_n) begin
        wb_dat_i = cur_slv.data;
        wb_ack_i = (cur_slv.mode == M_ACK) || (cur_slv.mode == M_BOTH);
        wb_err_i = (cur_slv.mode == M_ERR) || (cur_slv.mode == M_BOTH);
      end
      acc_n++;
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (in_acc) begin
        in_acc = 1'b0;
        obs_q.push_back(cur_obs);
      end
    end

    resp = if_done | if_err | d_done | d_err;
    if (resp) begin
      resp_cnt++;
      check("no_overlap", 64'((if_done | if_err) & (d_done | d_err)), 64'd0);
      check("pulse_one_cycle", 64'(prev_resp), 64'd0);
      if (exp_q.size() == 0) begin
        check("exp_avail", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("owner", 64'(d_done | d_err), 64'(e.is_d));
        check("err",   64'(e.is_d ? d_err  : if_err),  64'(e.err));
        check("done",  64'(e.is_d ? d_done : if_done), 64'(!e.err));
        check("rdata", 64'(e.is_d ? d_rdata : if_rdata), 64'(e.rdata));
        check("other_rdata", 64'(e.is_d ? if_rdata : d_rdata), 64'(e.other_rdata));
        if (obs_q.size() == 0) begin
          check("bus_obs_avail", 64'd0, 64'd1);
        end else begin
          o = obs_q.pop_front();
          check("bus_addr",   64'(o.addr),   64'(e.addr));
          check("bus_we",     64'(o.we),     64'(e.we));
          check("bus_sel",    64'(o.sel),    64'(e.sel));
          check("bus_wdata",  64'(o.wdata),  64'(e.wdata));
          check("bus_len",    64'(o.len),    64'(e.len));
          check("bus_stable", 64'(o.stable), 64'd1);
        end
      end
    end
    prev_resp = resp;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic expect_access(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] sel,
                               input int mode, input int wait_n, input logic [31:0] rdat);
    exp_t e;
    bit   weff;
    slv_t s;
    s = '{mode: mode, wait_n: wait_n, data: rdat};
    slv_q.push_back(s);
    weff    = is_d ? we : 1'b0;
    e.is_d  = is_d;
    e.err   = (mode == M_ERR) || (mode == M_NONE);
    if (!e.err && !weff) mdl_rdata[is_d] = rdat;
    e.rdata       = mdl_rdata[is_d];
    e.other_rdata = mdl_rdata[!is_d];
    e.len   = (mode == M_NONE) ? TO : wait_n + 1;
    e.addr  = addr;
    e.we    = weff;
    e.sel   = is_d ? sel : 4'hF;
    e.wdata = is_d ? wdata : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input int target, input int budget, input string tag);
    int i;
    for (i = 0; i < budget && resp_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (resp_cnt < target) check({tag, "_no_response"}, 64'd0, 64'd1);
  endtask

  task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel,
                           input int mode, input int wait_n, input logic [31:0] rdat,
                           input string tag);
    int t0;
    int start;
    expect_access(is_d, we, addr, wdata, sel, mode, wait_n, rdat);
    @(posedge clk);
    #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_sel = sel;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    t0    = cyc_cnt;
    start = resp_cnt;
    wait_resp(start + 1, 100, tag);
    check({tag, "_latency"}, 64'(cyc_cnt - t0),
          64'((mode == M_NONE) ? TO + 1 : wait_n + 2));
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0;
    else      if_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int start;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
    check("rst_bus_fields", 64'({wb_adr_o, wb_sel_o}), 64'd0);
    check("rst_wdata", 64'(wb_dat_o), 64'd0);
    check("rst_pulses", 64'({if_done, if_err, d_done, d_err}), 64'd0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    reset = 1'b0;

    // IF read, zero wait states
    do_access(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, M_ACK, 0, 32'hDEAD_BEEF, "if_read");
    // D read with one wait state, then D write with two (rdata must hold)
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, M_ACK, 1, 32'hCAFE_F00D, "d_read");
    do_access(1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'h3, M_ACK, 2, 32'hFFFF_FFFF, "d_write");
    // D timeout: slave never answers
    do_access(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, M_NONE, 0, 32'h0BAD_0BAD, "d_timeout");
    // IF bus error alone, then ack and err together (ack wins)
    do_access(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, M_ERR, 0, 32'h7777_7777, "if_err");
    do_access(1'b0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, M_BOTH, 1, 32'h0BAD_F00D, "if_ack_err");

    // Reset in the second BUS cycle of a D read: access is dropped silently
    slv_q.push_back('{mode: M_NONE, wait_n: 0, data: 32'h0});
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080; d_sel = 4'hF;
    start = resp_cnt;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rstmid_cyc_before", 64'(wb_cyc_o), 64'd1);
    reset = 1'b1;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_cyc_dropped", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid_no_response", 64'(resp_cnt), 64'(start));
    obs_q.delete();
    slv_q.delete();
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    do_access(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0, M_ACK, 0, 32'h5A5A_0001, "post_rst_read");

    // Contention: both held continuously from one cycle after reset
    pulse_reset();
    expect_access(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, M_ACK, 0, 32'h1111_1111);
    expect_access(1'b1, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 4'hF, M_ACK, 1, 32'hEEEE_EEEE);
    expect_access(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, M_ACK, 0, 32'h2222_2222);
    expect_access(1'b1, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 4'hF, M_ACK, 1, 32'hEEEE_EEEE);
    start = resp_cnt;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'hA5A5_A5A5; d_sel = 4'hF;
    wait_resp(start + 4, 200, "contention");
    @(posedge clk);
    #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("contention_quiet_cyc", 64'(wb_cyc_o), 64'd0);
    check("contention_resp_count", 64'(resp_cnt - start), 64'd4);
    check("contention_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_wb_mem_arbiter

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Shares the single Wishbone memory master port between two requesters of the multicycle RISC-V core: the instruction-fetch unit (IF, read-only) and the load/store unit (D, read/write).
- Arbitrates requests with 2-way round-robin and sequences one classic Wishbone cycle per grant.
- Returns read data with a one-cycle done/err pulse to the owning requester.
- Sits between the core's fetch/LSU and the memory-controller side of the Wishbone interface.

Parameters:
- AW, 32, address width.
- DW, 32, data width; wb_sel_o width is DW/8.
- TIMEOUT, 255, cycles in BUS without ack/err before abort; range 1..65535.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  IF read request; held until if_done/if_err.
- if_addr  in  AW  IF address.
- if_rdata  out  DW  IF read data.
- if_done  out  1  IF success pulse.
- if_err  out  1  IF bus error/timeout pulse.
- d_req  in  1  D request; held until d_done/d_err.
- d_we  in  1  D write enable.
- d_addr  in  AW  D address.
- d_wdata  in  DW  D write data.
- d_sel  in  DW/8  D byte lanes.
- d_rdata  out  DW  D read data.
- d_done  out  1  D success pulse.
- d_err  out  1  D error pulse.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_adr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  DW/8  Wishbone byte lanes.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack_i, wb_err_i  in  1 each  Wishbone slave termination.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all outputs 0, last_gnt=D so IF wins the first tie, timeout counter=0. Reset asserted mid-transaction drops cyc/stb at that edge. No done/err is issued for the aborted access.
- FSM states: IDLE, BUS, RESP. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester opposite last_gnt.
  - On grant, latch owner, addr, we, wdata and sel. IF always latches we=0, sel=all-ones, wdata=0. Update last_gnt, clear the counter, go to BUS.
- BUS:
  - wb_cyc_o=wb_stb_o=1; address, data and controls driven from the latched registers and stable for the whole cycle.
  - wb_ack_i=1: capture wb_dat_i into the owner's rdata (reads only; writes leave rdata unchanged), set done for the owner, drop cyc/stb, go to RESP.
  - Else wb_err_i=1: set err for the owner, drop cyc/stb, go to RESP. If ack and err are both high, ack wins.
  - Else counter==TIMEOUT-1: set err for the owner, drop cyc/stb, go to RESP.
  - Else increment the counter.
- RESP: done/err is high for exactly this one cycle, then IDLE. Requests are ignored in RESP.
- Requester rule: req must fall at the edge ending its done/err cycle. If req is still high in the following IDLE cycle, it is a new request using the current address.
- A requester that drops req while in BUS does not cancel the access. The cycle completes and done/err still pulses.
- rdata holds its value until the next successful read by the same requester.
- Latency: req seen in IDLE at cycle 0 → cyc/stb at cycle 1 → ack at cycle 1+w → done at cycle 2+w. Minimum 3 cycles from request to the next IDLE.
- Fairness: with both requesters continuously requesting, grants alternate IF, D, IF, D.
- Simultaneous request and reset: reset wins.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state encoding (IDLE, BUS, RESP);
  - owner IDs (OWN_IF=0, OWN_D=1);
  - default TIMEOUT;
  - the Wishbone width constants.
- One sub-module, rr_arb2: 2-way round-robin grant logic, with inputs req[1:0] and last_gnt and outputs gnt and gnt_id, purely combinational. The FSM, counter and datapath stay in wb_mem_arbiter.

Test Plan:
- IF-only read: if_req=1, if_addr=0x100, slave acks on the first BUS cycle with 0xDEADBEEF → wb_adr_o=0x100, we=0, sel=0xF; if_done=1 at cycle 3 and if_rdata=0xDEADBEEF.
- D write: d_we=1, d_addr=0x2004, d_wdata=0x12345678, d_sel=0x3, slave inserts 2 wait states → cyc high for 3 cycles; d_done at cycle 5; d_rdata unchanged.
- Contention: both requests held continuously starting 1 cycle after reset → grant order IF, D, IF, D across 4 transactions; no done pulse overlaps.
- Timeout: TIMEOUT=4, slave never acks → cyc held for 4 cycles, then d_err pulses once, then IDLE.
- Bus error plus simultaneous ack/err: wb_err_i alone → if_err=1; ack and err together → done=1, err=0.
- Reset mid-BUS: reset asserted in the 2nd BUS cycle → cyc/stb drop at the next edge, no done/err, the next request is granted normally.
